// File: rtl/vector_multiplier_if.sv
// vector_multiplier_if: operand-in / product-out valid-ready channels of the multiplier stage
interface vector_multiplier_if #(
    parameter int DIM = 8,
    parameter int W   = 32
);
    logic               in_valid, in_ready, in_last;
    logic [DIM*W-1:0]   a_vec, b_vec;
    logic               out_valid, out_ready, out_last;
    logic [DIM*2*W-1:0] prod_vec;
    modport slave (
        input  in_valid, a_vec, b_vec, in_last, out_ready,
        output in_ready, out_valid, prod_vec, out_last
    );
    modport master (
        output in_valid, a_vec, b_vec, in_last, out_ready,
        input  in_ready, out_valid, prod_vec, out_last
    );
endinterface

// File: rtl/vector_multiplier.sv
// vector_multiplier: two-stage element-wise unsigned multiplier with valid/ready backpressure
module vector_multiplier #(
    parameter int DIM = 8,
    parameter int W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_multiplier_if.slave vm,
    output logic [15:0]        o_done_count
);
    logic [DIM*W-1:0]   r_s1_a, r_s1_b;
    logic               r_s1_last, r_s1_v;
    logic [DIM*2*W-1:0] r_s2_prod, w_prod;
    logic               r_s2_last, r_s2_v;
    logic               w_s1_load, w_s2_load;
    logic [15:0]        r_done;

    // a stage may advance whenever the stage ahead of it is empty or draining
    assign w_s2_load   = !r_s2_v || vm.out_ready;
    assign w_s1_load   = !r_s1_v || w_s2_load;
    assign vm.in_ready = w_s1_load;
    assign vm.out_valid = r_s2_v;
    assign vm.prod_vec  = r_s2_prod;
    assign vm.out_last  = r_s2_last;
    assign o_done_count = r_done;

    genvar i;
    generate
        for (i = 0; i < DIM; i++) begin : g_mul
            assign w_prod[2*W*i +: 2*W] = {{W{1'b0}}, r_s1_a[W*i +: W]} * {{W{1'b0}}, r_s1_b[W*i +: W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_last <= 1'b0;
            r_s1_v    <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_a    <= vm.a_vec;
            r_s1_b    <= vm.b_vec;
            r_s1_last <= vm.in_last;
            r_s1_v    <= vm.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_prod <= '0;
            r_s2_last <= 1'b0;
            r_s2_v    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_prod <= w_prod;
            r_s2_last <= r_s1_last;
            r_s2_v    <= r_s1_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_done <= '0;
        else if (r_s2_v && vm.out_ready && r_s2_last)
            r_done <= r_done + 16'd1;
    end
endmodule

// File: tb/tb_vector_multiplier.sv
// tb_vector_multiplier: directed table vectors plus scoreboarded streaming, backpressure, reset and count-wrap sequences
module tb_vector_multiplier;
    logic        clk, rst_n;
    logic [15:0] o_done_count;
    int          n_chk = 0, n_fail = 0;

    vector_multiplier_if #(.DIM(8), .W(32)) vm();
    vector_multiplier #(.DIM(8), .W(32)) dut (.clk(clk), .rst_n(rst_n), .vm(vm), .o_done_count(o_done_count));

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct { logic [255:0] a, b; logic l; logic [511:0] p; } vec_t;
    typedef struct { logic [511:0] p; logic l; int c; } exp_t;
    vec_t        tbl[4];
    exp_t        q[$];
    logic [15:0] exp_done = 0;
    int          cyc = 0;
    bit          lat_en = 0, bp_en = 0, stall = 0;
    logic [511:0] held_p;
    logic        held_l;

    task automatic chk(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        for (int i = 0; i < 8; i++) p[64*i +: 64] = 64'(a[32*i +: 32]) * 64'(b[32*i +: 32]);
        return p;
    endfunction

    function automatic logic [255:0] rv();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            cyc++;
            chk(vm.in_ready === !(q.size() == 2 && !vm.out_ready), "in_ready", 512'(vm.in_ready), 512'(!(q.size() == 2 && !vm.out_ready)));
            chk(o_done_count === exp_done, "done_count", 512'(o_done_count), 512'(exp_done));
            if (stall)
                chk(vm.out_valid === 1'b1 && vm.prod_vec === held_p && vm.out_last === held_l, "stall_hold", vm.prod_vec, held_p);
            if (vm.out_valid) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_output", vm.prod_vec, 0);
                end else begin
                    chk(vm.prod_vec === q[0].p && vm.out_last === q[0].l, "prod_vec", {vm.prod_vec[510:0], vm.out_last}, {q[0].p[510:0], q[0].l});
                    if (lat_en) chk(cyc - q[0].c == 2, "latency", 512'(cyc - q[0].c), 512'(2));
                    if (vm.out_ready) begin
                        if (q[0].l) exp_done++;
                        void'(q.pop_front());
                    end
                end
            end
            stall  = vm.out_valid && !vm.out_ready;
            held_p = vm.prod_vec;
            held_l = vm.out_last;
            if (vm.in_valid && vm.in_ready) q.push_back('{model(vm.a_vec, vm.b_vec), vm.in_last, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) vm.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [255:0] a, input logic [255:0] b, input logic l);
        bit acc = 0;
        vm.in_valid = 1; vm.a_vec = a; vm.b_vec = b; vm.in_last = l;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = vm.in_ready;
            tick();
        end
        vm.in_valid = 0;
        if (!acc) chk(0, "send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        chk(q.size() == 0, "drain", 512'(q.size()), 0);
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        q.delete();
        exp_done = 0;
        chk(vm.out_valid === 1'b0, "rst_out_valid", 512'(vm.out_valid), 0);
        chk(vm.in_ready === 1'b1, "rst_in_ready", 512'(vm.in_ready), 1);
        chk(o_done_count === 16'h0, "rst_done_count", 512'(o_done_count), 0);
        chk(vm.prod_vec === '0 && vm.out_last === 1'b0, "rst_prod", vm.prod_vec, 0);
        @(posedge clk);
        #3 rst_n = 1;
        tick();
    endtask

    initial begin
        rst_n = 0;
        vm.in_valid = 0; vm.a_vec = '0; vm.b_vec = '0; vm.in_last = 0; vm.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tbl[0].a[32*i +: 32] = 32'(i + 1);      tbl[0].b[32*i +: 32] = 32'd2;
            tbl[0].p[64*i +: 64] = 64'(2 * (i + 1));
            tbl[1].a[32*i +: 32] = 32'hFFFFFFFF;    tbl[1].b[32*i +: 32] = 32'hFFFFFFFF;
            tbl[1].p[64*i +: 64] = 64'hFFFFFFFE00000001;
            tbl[2].a[32*i +: 32] = 32'h0;           tbl[2].b[32*i +: 32] = 32'hDEADBEEF;
            tbl[2].p[64*i +: 64] = 64'h0;
            tbl[3].a[32*i +: 32] = 32'h80000000;    tbl[3].b[32*i +: 32] = 32'(i);
            tbl[3].p[64*i +: 64] = 64'(i) << 31;
        end
        tbl[0].l = 0; tbl[1].l = 1; tbl[2].l = 0; tbl[3].l = 1;
        do_reset();

        foreach (tbl[t]) begin
            send(tbl[t].a, tbl[t].b, tbl[t].l);
            @(negedge clk);
            chk(vm.out_valid === 1'b0, "tbl_early_valid", 512'(vm.out_valid), 0);
            @(negedge clk);
            chk(vm.out_valid === 1'b1 && vm.prod_vec === tbl[t].p && vm.out_last === tbl[t].l, "tbl_prod", vm.prod_vec, tbl[t].p);
            tick();
        end
        drain();

        // two vectors parked in the pipeline when reset hits
        vm.out_ready = 0;
        send(rv(), rv(), 1);
        send(rv(), rv(), 1);
        chk(q.size() == 2 && vm.in_ready === 1'b0, "two_in_flight", 512'(q.size()), 2);
        do_reset();
        vm.out_ready = 1;
        for (int k = 0; k < 5; k++) tick();
        chk(vm.out_valid === 1'b0, "no_stale_output", 512'(vm.out_valid), 0);

        lat_en = 1;
        for (int k = 0; k < 100; k++) send(rv(), rv(), 0);
        drain();
        lat_en = 0;

        bp_en = 1;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 1) == 1) tick();
            send(rv(), rv(), 1'($urandom_range(0, 1)));
        end
        bp_en = 0;
        vm.out_ready = 1;
        drain();

        do_reset();
        for (int k = 0; k < 65537; k++) send(rv(), rv(), 1);
        for (int k = 0; k < 3; k++) send(rv(), rv(), 0);
        drain();
        @(negedge clk);
        chk(o_done_count === 16'h0001, "done_wrap", 512'(o_done_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vector_multiplier.md
# vector_multiplier

Element-wise multiplier stage for the dot-product datapath: takes one row operand vector and one column operand vector of DIM elements each and produces the DIM-element product vector consumed directly by the downstream summation tree. It is a two-stage registered pipeline with a valid/ready handshake on both sides and full backpressure support. It also passes through an end-of-row marker and counts completed rows.

## Interface
- DIM, 8, elements per vector; any value ≥ 1
- W, 32, width of each unsigned input element
- Clock  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents a_vec/b_vec/in_last
- in_ready  output  1  block accepts this cycle; transfer when in_valid && in_ready
- a_vec  input  DIM*W  operand A; element i at [W*i +: W]
- b_vec  input  DIM*W  operand B; same packing
- in_last  input  1  marks final vector pair of a row
- out_valid  output  1  prod_vec/out_last valid
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
- prod_vec  output  DIM*2W  element i = a_i * b_i at [2W*i +: 2W]
- out_last  output  1  in_last of the vector currently on prod_vec
- done_count  output  16  number of output transfers with out_last=1, modulo 2^16

## Operation
- Stage 1 (S1): registers a_vec, b_vec, in_last, plus valid bit s1_v.
- Stage 2 (S2): registers DIM products of S1 operands, S1 last, plus valid bit s2_v; s2_v drives out_valid and S2 registers drive prod_vec/out_last.
- Arithmetic: unsigned, full 2W-bit product per element; no truncation, no saturation.
- s2_load = !s2_v || out_ready. On s2_load, S2 takes S1 contents and s2_v <= s1_v.
- s1_load = !s1_v || s2_load. On s1_load, S1 takes inputs and s1_v <= in_valid.
- in_ready = s1_load (combinational from out_ready, s1_v, s2_v).
- No stage holds a bubble while the other is stalled; both stages full and out_ready=0 is the only condition that drops in_ready.
- Stalled stage holds data; prod_vec and out_last remain stable while out_valid && !out_ready.
- Data registers may load when the corresponding valid is 0; only valid bits are observable.
- done_count increments by 1 on each output transfer with out_last=1; wraps 0xFFFF -> 0x0000.
- in_valid deasserted: input data ignored; no transfer.

## Timing
- Reset (Reset_n=0, asynchronous): s1_v=0, s2_v=0, out_valid=0, prod_vec=0, out_last=0, done_count=0; in_ready=1 immediately after reset since s1_v=0.
- Reset mid-operation: all in-flight vectors discarded; no output transfer occurs for them after release.
- Latency: input accepted at edge N -> out_valid=1 with its products after edge N+1, i.e., 2 cycles accept-to-present.
- Throughput: 1 vector/cycle with out_ready held 1.
- Backpressure: out_ready=0 with both stages full -> in_ready=0 in the same cycle; in_ready returns to 1 in the same cycle that out_ready returns to 1.
- Simultaneous out transfer and in accept with both stages full: S2 takes S1 and S1 takes the new input on the same edge; no data lost or duplicated.
- done_count updates on the edge of the qualifying transfer and is visible the following cycle.

## Test plan
- Reset: assert Reset_n=0 mid-stream with 2 vectors in flight -> out_valid=0, done_count=0, in_ready=1; after release, no stale output ever appears.
- Basic product: DIM=8, W=32, a_i=i+1, b_i=2, out_ready=1 -> prod_vec elements 2,4,...,16 with out_valid exactly 2 cycles after accept.
- Width extremes: all a_i=b_i=0xFFFFFFFF -> every element 0xFFFFFFFE00000001; a_i=0 -> element 0.
- Streaming: 100 back-to-back random vectors, out_ready=1 -> 100 outputs in order, one per cycle, matching a reference model.
- Backpressure: random out_ready (50%) with random in_valid over 1000 vectors -> in order, no loss or duplication; prod_vec stable during every stall; in_ready=0 only when both stages full and out_ready=0.
- Last/count: 65537 transfers each with in_last=1 -> out_last follows its vector; done_count reads 0x0001 after wrap; vectors with in_last=0 do not increment the count.
